uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_select.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and default BUSY_TIMEOUT shared by the UART TX arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int DEFAULT_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: round-robin winner search starting just above last_grant.
//   req        in  N     request vector
//   last_grant in  W     index granted most recently
//   winner     out W     first requesting index at or after (last_grant+1) mod N
//   any        out 1     at least one request present
module rr_select #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(last_grant) + k) % N);
            if (req[idx]) winner = idx;
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes from NUM_REQ requesters to one UART transmitter.
//   clk         in  1           system clock, rising edge
//   rst         in  1           asynchronous active-low reset
//   timeout_err out 1           one-cycle pulse when tx_busy never rises (only with UART_ARB_TIMEOUT_EN)
//   req_valid   in  NUM_REQ     requester i has a byte pending
//   req_data    in  8*NUM_REQ   byte of requester i at [8i+7:8i]
//   req_ready   out NUM_REQ     one-cycle accept pulse
//   cfg_pen     in  1           parity enable for the next accepted byte
//   cfg_peven   in  1           even parity select for the next accepted byte
//   tx_en       out 1           one-cycle start pulse to the transmitter
//   tx_din      out 8           byte held for the whole frame
//   tx_pen      out 1           parity enable latched at accept
//   tx_peven    out 1           even parity select latched at accept
//   tx_busy     in  1           transmitter busy flag
//   grant_id    out clog2(N)    requester owning the current frame
//   active      out 1           high from accept until the frame completes
// Optional feature macro: UART_ARB_TIMEOUT_EN adds the WAIT_BUSY timeout and the timeout_err port.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
    localparam int GW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_ARB_TIMEOUT_EN
    output logic                 timeout_err,
`endif
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 cfg_pen,
    input  logic                 cfg_peven,
    output logic                 tx_en,
    output logic [7:0]           tx_din,
    output logic                 tx_pen,
    output logic                 tx_peven,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 active
);

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner;
    logic          any;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    logic [CW-1:0] cnt;
`endif

    rr_select #(.N(NUM_REQ), .W(GW)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            req_ready   <= '0;
            tx_en       <= 1'b0;
            tx_din      <= '0;
            tx_pen      <= 1'b0;
            tx_peven    <= 1'b0;
            grant_id    <= '0;
            active      <= 1'b0;
            last_grant  <= GW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            req_ready   <= '0;
            tx_en       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any && !tx_busy) begin
                        state     <= ISSUE;
                        tx_din    <= req_data[8*winner +: 8];
                        tx_pen    <= cfg_pen;
                        tx_peven  <= cfg_peven;
                        grant_id  <= winner;
                        req_ready <= NUM_REQ'(1) << winner;
                        active    <= 1'b1;
                    end
                end
                ISSUE: begin
                    tx_en <= 1'b1;
                    state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        active      <= 1'b0;
                        last_grant  <= grant_id;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state      <= IDLE;
                        active     <= 1'b0;
                        last_grant <= grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed plus randomized frames checked against a round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk       = 1'b0;
    logic           rst       = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic           cfg_pen   = 1'b0;
    logic           cfg_peven = 1'b0;
    logic           tx_en;
    logic [7:0]     tx_din;
    logic           tx_pen;
    logic           tx_peven;
    logic           tx_busy   = 1'b0;
    logic [1:0]     grant_id;
    logic           active;
`ifdef UART_ARB_TIMEOUT_EN
    logic           timeout_err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int last        = N - 1;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef UART_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cfg_pen     (cfg_pen),
        .cfg_peven   (cfg_peven),
        .tx_en       (tx_en),
        .tx_din      (tx_din),
        .tx_pen      (tx_pen),
        .tx_peven    (tx_peven),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] m, input int l);
        for (int k = 1; k <= N; k++)
            if (m[(l + k) % N]) return (l + k) % N;
        return 0;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_tx_en"}, 32'(tx_en), 0);
        chk({tag, "_tx_din"}, 32'(tx_din), 0);
        chk({tag, "_tx_pen"}, 32'(tx_pen), 0);
        chk({tag, "_tx_peven"}, 32'(tx_peven), 0);
        chk({tag, "_grant_id"}, 32'(grant_id), 0);
        chk({tag, "_active"}, 32'(active), 0);
`ifdef UART_ARB_TIMEOUT_EN
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
`endif
    endtask

    // One complete frame from the current req_valid; next_mask is applied right after accept.
    task automatic frame(input logic [N-1:0] next_mask, input int dly, input int len);
        int         w;
        logic [7:0] b;
        logic       p;
        logic       pe;
        w  = pick(req_valid, last);
        b  = req_data[8*w +: 8];
        p  = cfg_pen;
        pe = cfg_peven;
        tick;
        chk("accept_ready", 32'(req_ready), 32'(1) << w);
        chk("accept_grant", 32'(grant_id), 32'(w));
        chk("accept_active", 32'(active), 1);
        chk("accept_tx_en", 32'(tx_en), 0);
        req_data[8*w +: 8] = 8'($urandom);
        req_valid = next_mask;
        cfg_pen   = ~cfg_pen;
        cfg_peven = ~cfg_peven;
        tick;
        chk("issue_tx_en", 32'(tx_en), 1);
        chk("issue_ready", 32'(req_ready), 0);
        chk("issue_tx_din", 32'(tx_din), 32'(b));
        for (int i = 0; i < dly; i++) begin
            tick;
            chk("wait_tx_en", 32'(tx_en), 0);
            chk("wait_ready", 32'(req_ready), 0);
            chk("wait_active", 32'(active), 1);
        end
        tx_busy = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick;
            chk("busy_ready", 32'(req_ready), 0);
            chk("busy_active", 32'(active), 1);
            chk("busy_tx_din", 32'(tx_din), 32'(b));
            chk("busy_tx_pen", 32'(tx_pen), 32'(p));
            chk("busy_tx_peven", 32'(tx_peven), 32'(pe));
            chk("busy_grant", 32'(grant_id), 32'(w));
        end
        tx_busy = 1'b0;
        tick;
        chk("done_active", 32'(active), 0);
        chk("done_ready", 32'(req_ready), 0);
        last = w;
    endtask

    initial begin
        int w;
        logic [N-1:0] m;
        req_valid = 4'b1111;
        #12;
        chk_reset_outputs("in_reset");
        tick;
        chk("in_reset_no_accept", 32'(req_ready), 0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        tick;
        chk("idle_no_req", 32'(req_ready), 0);
        tick;
        chk("idle_no_req_active", 32'(active), 0);
        tx_busy        = 1'b1;
        req_valid      = 4'b0001;
        req_data[7:0]  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("idle_busy_hold", 32'(req_ready), 0);
        end
        tx_busy   = 1'b0;
        cfg_pen   = 1'b1;
        cfg_peven = 1'b0;
        frame(4'b0100, 2, 4);
        chk("single_req_last", 32'(last), 0);
        frame(4'b1111, 1, 3);
        chk("late_req_grant", 32'(last), 2);
        for (int i = 0; i < 5; i++) frame(4'b1111, 0, 2);
        chk("rr_all_last", 32'(last), 3);
        for (int i = 0; i < 24; i++) begin
            m         = N'($urandom_range(1, (1 << N) - 1));
            cfg_pen   = 1'($urandom);
            cfg_peven = 1'($urandom);
            frame(m, $urandom_range(0, 4), $urandom_range(1, 6));
        end
`ifdef UART_ARB_TIMEOUT_EN
        w = pick(req_valid, last);
        tick;
        chk("to_accept", 32'(req_ready), 32'(1) << w);
        req_valid = '0;
        tick;
        chk("to_tx_en", 32'(tx_en), 1);
        for (int i = 0; i < 15; i++) begin
            tick;
            chk("to_pending", 32'(timeout_err), 0);
            chk("to_active", 32'(active), 1);
        end
        tick;
        chk("to_pulse", 32'(timeout_err), 1);
        chk("to_idle", 32'(active), 0);
        tick;
        chk("to_pulse_end", 32'(timeout_err), 0);
        last = w;
        req_valid = 4'b0110;
        frame(4'b0110, 1, 2);
`endif
        req_valid = 4'b1110;
        w = pick(req_valid, last);
        tick;
        chk("rst_case_accept", 32'(req_ready), 32'(1) << w);
        tick;
        tx_busy = 1'b1;
        tick;
        chk("rst_case_wait_done", 32'(active), 1);
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        tx_busy   = 1'b0;
        req_valid = 4'b1111;
        tick;
        chk("held_rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst  = 1'b1;
        last = N - 1;
        frame(4'b0000, 1, 2);
        chk("post_rst_grant", 32'(last), 0);
        tick;
        chk("drained_ready", 32'(req_ready), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
